result_checker: RTL and testbench
=================================

Name: result_checker

Overview:
- Self-checking comparison stage sitting directly downstream of a datapath DUT (SHL, SHR, ADD, etc.) in a component bench.
- Consumes the DUT's measured output and the bench's reference value.
- Aligns the reference to the DUT's pipeline latency, compares every qualified cycle, and reports per-cycle error, sticky error, pass/fail counts and a capture of the first failing pair.
- Extends the per-cycle compare to pipelined (registered) components.

Parameters:
- DATAWIDTH, 32, width of d_meas/d_ref.
- LATENCY, 0, cycles d_meas lags d_ref/valid; legal 0..15.
- CNTWIDTH, 16, width of all counters/index outputs.
- MAX_ERRORS, 0, error count at which checking halts; 0 = never halt.

Ports:
- clk  in  1  bench clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- d_meas  in  DATAWIDTH  DUT output.
- d_ref  in  DATAWIDTH  expected value, presented same cycle as matching DUT input.
- valid  in  1  qualifies d_ref this cycle.
- err  out  1  registered one-cycle pulse per mismatch.
- err_sticky  out  1  set on first mismatch, cleared only by rst.
- err_count  out  CNTWIDTH  mismatches, saturating.
- chk_count  out  CNTWIDTH  compares performed, saturating.
- first_err_meas  out  DATAWIDTH  d_meas at first mismatch.
- first_err_ref  out  DATAWIDTH  aligned d_ref at first mismatch.
- first_err_idx  out  CNTWIDTH  chk_count value (0-based) of first mismatch.
- state  out  2  00 IDLE, 01 RUN, 10 FAIL, 11 HALT.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - All outputs go to 0; state=IDLE.
  - Delay line (d_ref, valid) cleared.
  - No compare may occur until delayed valid is 1, i.e. at least LATENCY cycles after rst deasserts.
- Alignment:
  - LATENCY stages of registers carry {valid, d_ref}; ref_a/valid_a are the last stage.
  - With LATENCY=0, ref_a/valid_a are the current inputs.
- Compare: at each posedge with valid_a=1 and state!=HALT:
  - mismatch = (d_meas !== ref_a); an X/Z bit in d_meas counts as a mismatch.
  - chk_count increments.
  - On mismatch: err=1 next cycle, err_count increments.
  - Otherwise err=0.
  - When valid_a=0, err=0 and counters hold.
- First-error capture:
  - Loaded only when err_sticky is 0 at the compare edge.
  - first_err_idx = chk_count before increment.
  - Values are never overwritten afterwards.
- Saturation: counters stop at 2^CNTWIDTH-1; first_err_idx is captured from the saturated value if applicable.
- State machine (registered, transitions on the compare edge):
  - IDLE -> RUN on first passing compare.
  - IDLE or RUN -> FAIL on mismatch.
  - FAIL -> HALT when MAX_ERRORS!=0 and the post-increment err_count == MAX_ERRORS.
  - IDLE -> HALT directly if MAX_ERRORS=1 and the first compare fails.
  - FAIL never returns to RUN.
  - HALT is absorbing until rst: compares stop, counters and err freeze at 0 pulse.
- Simultaneous events: a mismatch on the compare that reaches MAX_ERRORS is counted and pulsed, then HALT.
- valid toggling: gaps in valid propagate through the delay line unchanged; no compare is skipped or duplicated.

Test Plan:
- LATENCY=0, DATAWIDTH=32, 8 cycles d_meas=d_ref=0x0000_00F0, valid=1 -> chk_count=8, err never high, state=RUN, err_sticky=0.
- LATENCY=2, d_ref sequence 1,2,3 with d_meas equal to the same sequence delayed 2 cycles -> 3 passes, no err.
- Same bench with d_meas delayed 1 cycle -> err pulses from the first compare, first_err_idx=0.
- LATENCY=0: inject d_meas=0xDEAD_BEEF vs d_ref=0xDEAD_BEEE at the 5th valid cycle -> err high one cycle later, err_count=1, first_err_meas=0xDEADBEEF, first_err_ref=0xDEADBEEE, first_err_idx=4, state=FAIL.
- MAX_ERRORS=3, continuous mismatches -> err_count stops at 3, state=HALT, err low after the 3rd pulse, chk_count frozen.
- Assert rst for 1 cycle mid-stream with LATENCY=3 -> all outputs 0 immediately, state=IDLE, first compare occurs no earlier than the 3rd posedge after release.
- CNTWIDTH=4, 20 passing compares -> chk_count=15.

Source files
------------

// File: rtl/result_checker_if.sv
// ---------------------------------------------------------------------------
// result_checker_if
// Groups the compare-stage bus of result_checker: the DUT sample and the
// reference stream going in, and the checking status coming back.
//   d_meas          DUT output under test
//   d_ref           reference value, presented with the matching DUT input
//   valid           qualifies d_ref this cycle
//   err             one-cycle pulse per mismatch (registered)
//   err_sticky      set on first mismatch, cleared only by reset
//   err_count       saturating mismatch count
//   chk_count       saturating compare count
//   first_err_meas  d_meas captured at the first mismatch
//   first_err_ref   aligned d_ref captured at the first mismatch
//   first_err_idx   0-based compare index of the first mismatch
//   state           00 IDLE, 01 RUN, 10 FAIL, 11 HALT
// master: the bench side (drives stimulus, observes status)
// slave : the checker side
// ---------------------------------------------------------------------------
interface result_checker_if #(
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 16
);
    logic [DATAWIDTH-1:0] d_meas;
    logic [DATAWIDTH-1:0] d_ref;
    logic                 valid;
    logic                 err;
    logic                 err_sticky;
    logic [CNTWIDTH-1:0]  err_count;
    logic [CNTWIDTH-1:0]  chk_count;
    logic [DATAWIDTH-1:0] first_err_meas;
    logic [DATAWIDTH-1:0] first_err_ref;
    logic [CNTWIDTH-1:0]  first_err_idx;
    logic [1:0]           state;

    modport master (
        output d_meas, d_ref, valid,
        input  err, err_sticky, err_count, chk_count,
        input  first_err_meas, first_err_ref, first_err_idx, state
    );

    modport slave (
        input  d_meas, d_ref, valid,
        output err, err_sticky, err_count, chk_count,
        output first_err_meas, first_err_ref, first_err_idx, state
    );
endinterface

// File: rtl/result_checker.sv
// ---------------------------------------------------------------------------
// result_checker
// Compare stage placed after a datapath DUT. The reference stream {valid,
// d_ref} is delayed by LATENCY register stages so it lines up with the DUT
// output, then every qualified cycle is compared and the outcome is tracked
// as a per-cycle error pulse, a sticky flag, saturating counters, a capture
// of the first failing pair and a small status FSM.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears status and the delay line
//   bus  result_checker_if.slave (stimulus in, status out)
// Parameters:
//   DATAWIDTH  data width of d_meas/d_ref
//   LATENCY    DUT pipeline depth, 0..15
//   CNTWIDTH   width of counters and index outputs (<= 32)
//   MAX_ERRORS mismatch count that halts checking; 0 never halts
// ---------------------------------------------------------------------------
module result_checker #(
    parameter int DATAWIDTH  = 32,
    parameter int LATENCY    = 0,
    parameter int CNTWIDTH   = 16,
    parameter int MAX_ERRORS = 0
) (
    input  logic              clk,
    input  logic              rst,
    result_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FAIL = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    localparam logic [CNTWIDTH-1:0] CNT_MAX = {CNTWIDTH{1'b1}};

    // Increment that sticks at the all-ones value.
    function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
        logic [CNTWIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNTWIDTH'(1);
        end
        return r;
    endfunction

    logic [DATAWIDTH-1:0] ref_a_s;
    logic                 valid_a_s;

    if (LATENCY == 0) begin : g_no_delay
        assign ref_a_s   = bus.d_ref;
        assign valid_a_s = bus.valid;
    end else begin : g_delay
        logic [DATAWIDTH-1:0] dly_ref_q   [LATENCY];
        logic [DATAWIDTH-1:0] dly_ref_d   [LATENCY];
        logic [LATENCY-1:0]   dly_valid_q;
        logic [LATENCY-1:0]   dly_valid_d;

        // Shift the reference stream one stage; valid gaps travel with it.
        always_comb begin
            dly_ref_d[0]   = bus.d_ref;
            dly_valid_d[0] = bus.valid;
            for (int i = 1; i < LATENCY; i++) begin
                dly_ref_d[i]   = dly_ref_q[i-1];
                dly_valid_d[i] = dly_valid_q[i-1];
            end
        end

        // Delay-line registers, cleared by reset so no stale compare follows it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dly_valid_q <= '0;
                dly_ref_q   <= '{default: '0};
            end else begin
                dly_valid_q <= dly_valid_d;
                dly_ref_q   <= dly_ref_d;
            end
        end

        assign ref_a_s   = dly_ref_q[LATENCY-1];
        assign valid_a_s = dly_valid_q[LATENCY-1];
    end

    state_t               state_q, state_d;
    logic                 err_q, err_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [CNTWIDTH-1:0]  err_count_q, err_count_d;
    logic [CNTWIDTH-1:0]  chk_count_q, chk_count_d;
    logic [DATAWIDTH-1:0] first_err_meas_q, first_err_meas_d;
    logic [DATAWIDTH-1:0] first_err_ref_q, first_err_ref_d;
    logic [CNTWIDTH-1:0]  first_err_idx_q, first_err_idx_d;
    logic                 do_cmp_s;
    logic                 mismatch_s;

    // Compare, counter update, first-error capture and next-state selection.
    always_comb begin
        state_d          = state_q;
        err_d            = 1'b0;
        err_sticky_d     = err_sticky_q;
        err_count_d      = err_count_q;
        chk_count_d      = chk_count_q;
        first_err_meas_d = first_err_meas_q;
        first_err_ref_d  = first_err_ref_q;
        first_err_idx_d  = first_err_idx_q;

        do_cmp_s   = valid_a_s && (state_q != ST_HALT);
        // Case inequality so an X/Z bit on the DUT output is a mismatch.
        mismatch_s = (bus.d_meas !== ref_a_s);

        if (do_cmp_s) begin
            chk_count_d = sat_inc(chk_count_q);
            if (mismatch_s) begin
                err_d        = 1'b1;
                err_sticky_d = 1'b1;
                err_count_d  = sat_inc(err_count_q);
                if (!err_sticky_q) begin
                    first_err_meas_d = bus.d_meas;
                    first_err_ref_d  = ref_a_s;
                    first_err_idx_d  = chk_count_q;
                end else begin
                    first_err_idx_d  = first_err_idx_q;
                end
                // The mismatch that reaches the limit is still counted and pulsed.
                if ((MAX_ERRORS != 0) && (32'(err_count_d) == 32'(MAX_ERRORS))) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FAIL;
                end
            end else begin
                if (state_q == ST_IDLE) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
        end else begin
            chk_count_d = chk_count_q;
        end
    end

    // Status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            err_q            <= 1'b0;
            err_sticky_q     <= 1'b0;
            err_count_q      <= '0;
            chk_count_q      <= '0;
            first_err_meas_q <= '0;
            first_err_ref_q  <= '0;
            first_err_idx_q  <= '0;
        end else begin
            state_q          <= state_d;
            err_q            <= err_d;
            err_sticky_q     <= err_sticky_d;
            err_count_q      <= err_count_d;
            chk_count_q      <= chk_count_d;
            first_err_meas_q <= first_err_meas_d;
            first_err_ref_q  <= first_err_ref_d;
            first_err_idx_q  <= first_err_idx_d;
        end
    end

    assign bus.state          = state_q;
    assign bus.err            = err_q;
    assign bus.err_sticky     = err_sticky_q;
    assign bus.err_count      = err_count_q;
    assign bus.chk_count      = chk_count_q;
    assign bus.first_err_meas = first_err_meas_q;
    assign bus.first_err_ref  = first_err_ref_q;
    assign bus.first_err_idx  = first_err_idx_q;

endmodule

// File: tb/tb_result_checker.sv
// ---------------------------------------------------------------------------
// tb_result_checker
// Four checker instances with different parameter sets share one clock and
// reset. A behavioural model (history arrays + integer counters) predicts
// every output every cycle; a vector table and hand-written sequences add
// fixed expectations for the documented scenarios.
//   inst0: LATENCY=0 MAX_ERRORS=0 CNTWIDTH=16
//   inst1: LATENCY=2 MAX_ERRORS=0 CNTWIDTH=16
//   inst2: LATENCY=3 MAX_ERRORS=3 CNTWIDTH=16
//   inst3: LATENCY=0 MAX_ERRORS=1 CNTWIDTH=4
// ---------------------------------------------------------------------------
module tb_result_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    result_checker_if #(.DATAWIDTH(32), .CNTWIDTH(16)) if_a ();
    result_checker_if #(.DATAWIDTH(32), .CNTWIDTH(16)) if_b ();
    result_checker_if #(.DATAWIDTH(32), .CNTWIDTH(16)) if_c ();
    result_checker_if #(.DATAWIDTH(32), .CNTWIDTH(4))  if_d ();

    logic [31:0] in_meas  [4];
    logic [31:0] in_ref   [4];
    logic        in_valid [4];

    assign if_a.d_meas = in_meas[0]; assign if_a.d_ref = in_ref[0]; assign if_a.valid = in_valid[0];
    assign if_b.d_meas = in_meas[1]; assign if_b.d_ref = in_ref[1]; assign if_b.valid = in_valid[1];
    assign if_c.d_meas = in_meas[2]; assign if_c.d_ref = in_ref[2]; assign if_c.valid = in_valid[2];
    assign if_d.d_meas = in_meas[3]; assign if_d.d_ref = in_ref[3]; assign if_d.valid = in_valid[3];

    result_checker #(.DATAWIDTH(32), .LATENCY(0), .CNTWIDTH(16), .MAX_ERRORS(0))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    result_checker #(.DATAWIDTH(32), .LATENCY(2), .CNTWIDTH(16), .MAX_ERRORS(0))
        u_b (.clk(clk), .rst(rst), .bus(if_b));
    result_checker #(.DATAWIDTH(32), .LATENCY(3), .CNTWIDTH(16), .MAX_ERRORS(3))
        u_c (.clk(clk), .rst(rst), .bus(if_c));
    result_checker #(.DATAWIDTH(32), .LATENCY(0), .CNTWIDTH(4),  .MAX_ERRORS(1))
        u_d (.clk(clk), .rst(rst), .bus(if_d));

    localparam int P_LAT  [4] = '{0, 2, 3, 0};
    localparam int P_MAX  [4] = '{0, 0, 3, 1};
    localparam int P_CMAX [4] = '{65535, 65535, 65535, 15};

    // ---------------- behavioural model state ----------------
    bit          hv [4][16];   // hv[i][k]: valid presented k+1 edges ago
    logic [31:0] hr [4][16];
    int          m_ec [4];
    int          m_cc [4];
    bit          m_err [4];
    bit          m_sticky [4];
    logic [31:0] m_fm [4];
    logic [31:0] m_fr [4];
    int          m_fidx [4];
    int          m_st [4];     // 0 IDLE, 1 RUN, 2 FAIL, 3 HALT

    // ---------------- observed outputs ----------------
    logic        o_err [4];
    logic        o_sticky [4];
    logic [31:0] o_ec [4];
    logic [31:0] o_cc [4];
    logic [31:0] o_fm [4];
    logic [31:0] o_fr [4];
    logic [31:0] o_fi [4];
    logic [1:0]  o_st [4];

    int errors = 0;
    int checks = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 16; k++) begin
                hv[i][k] = 1'b0;
                hr[i][k] = 32'h0;
            end
            m_ec[i] = 0; m_cc[i] = 0; m_err[i] = 1'b0; m_sticky[i] = 1'b0;
            m_fm[i] = 32'h0; m_fr[i] = 32'h0; m_fidx[i] = 0; m_st[i] = 0;
        end
    endtask

    // One clock edge of the checker rules for instance i.
    task automatic model_step(input int i);
        bit          av;
        logic [31:0] ar;
        int          lat;
        lat = P_LAT[i];
        if (lat == 0) begin
            av = in_valid[i];
            ar = in_ref[i];
        end else begin
            av = hv[i][lat-1];
            ar = hr[i][lat-1];
        end
        for (int k = 15; k > 0; k--) begin
            hv[i][k] = hv[i][k-1];
            hr[i][k] = hr[i][k-1];
        end
        hv[i][0] = in_valid[i];
        hr[i][0] = in_ref[i];
        m_err[i] = 1'b0;
        if (av && m_st[i] != 3) begin
            if (in_meas[i] !== ar) begin
                if (!m_sticky[i]) begin
                    m_fm[i]   = in_meas[i];
                    m_fr[i]   = ar;
                    m_fidx[i] = m_cc[i];
                end
                m_sticky[i] = 1'b1;
                m_err[i]    = 1'b1;
                if (m_ec[i] < P_CMAX[i]) m_ec[i] = m_ec[i] + 1;
                m_st[i] = (P_MAX[i] != 0 && m_ec[i] == P_MAX[i]) ? 3 : 2;
            end else if (m_st[i] == 0) begin
                m_st[i] = 1;
            end
            if (m_cc[i] < P_CMAX[i]) m_cc[i] = m_cc[i] + 1;
        end
    endtask

    task automatic sample();
        o_err[0] = if_a.err; o_sticky[0] = if_a.err_sticky; o_st[0] = if_a.state;
        o_ec[0] = 32'(if_a.err_count); o_cc[0] = 32'(if_a.chk_count); o_fi[0] = 32'(if_a.first_err_idx);
        o_fm[0] = if_a.first_err_meas; o_fr[0] = if_a.first_err_ref;
        o_err[1] = if_b.err; o_sticky[1] = if_b.err_sticky; o_st[1] = if_b.state;
        o_ec[1] = 32'(if_b.err_count); o_cc[1] = 32'(if_b.chk_count); o_fi[1] = 32'(if_b.first_err_idx);
        o_fm[1] = if_b.first_err_meas; o_fr[1] = if_b.first_err_ref;
        o_err[2] = if_c.err; o_sticky[2] = if_c.err_sticky; o_st[2] = if_c.state;
        o_ec[2] = 32'(if_c.err_count); o_cc[2] = 32'(if_c.chk_count); o_fi[2] = 32'(if_c.first_err_idx);
        o_fm[2] = if_c.first_err_meas; o_fr[2] = if_c.first_err_ref;
        o_err[3] = if_d.err; o_sticky[3] = if_d.err_sticky; o_st[3] = if_d.state;
        o_ec[3] = 32'(if_d.err_count); o_cc[3] = 32'(if_d.chk_count); o_fi[3] = 32'(if_d.first_err_idx);
        o_fm[3] = if_d.first_err_meas; o_fr[3] = if_d.first_err_ref;
    endtask

    task automatic cmp(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    task automatic check_model();
        sample();
        for (int i = 0; i < 4; i++) begin
            cmp("model_err",        i, 32'(o_err[i]),    32'(m_err[i]));
            cmp("model_err_sticky", i, 32'(o_sticky[i]), 32'(m_sticky[i]));
            cmp("model_err_count",  i, o_ec[i],          32'(m_ec[i]));
            cmp("model_chk_count",  i, o_cc[i],          32'(m_cc[i]));
            cmp("model_first_meas", i, o_fm[i],          m_fm[i]);
            cmp("model_first_ref",  i, o_fr[i],          m_fr[i]);
            cmp("model_first_idx",  i, o_fi[i],          32'(m_fidx[i]));
            cmp("model_state",      i, 32'(o_st[i]),     32'(m_st[i]));
        end
    endtask

    // Advance one edge; leaves time at posedge+1 with outputs checked.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 4; i++) model_step(i);
        end
        #1;
        check_model();
    endtask

    // Asynchronous reset pulse starting between edges, held across one edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b0; in_meas[i] = 32'h0; in_ref[i] = 32'h0;
        end
    endtask

    typedef struct {
        bit          rst_before;
        bit          valid;
        logic [31:0] mv;
        logic [31:0] rv;
        bit          exp_err;
        int          exp_ec;
        int          exp_cc;
        int          exp_st;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seq_v [5];
        logic [31:0] seq_r [5];
        logic [31:0] seq_m [5];
        logic [31:0] aligned;

        // Vector table for inst0 (LATENCY=0).
        for (int k = 0; k < 8; k++)
            vecs[k] = '{1'b0, 1'b1, 32'h0000_00F0, 32'h0000_00F0, 1'b0, 0, k + 1, 1};
        vecs[8]  = '{1'b0, 1'b0, 32'h1, 32'h2, 1'b0, 0, 8, 1};
        vecs[9]  = '{1'b1, 1'b1, 32'h11, 32'h11, 1'b0, 0, 1, 1};
        vecs[10] = '{1'b0, 1'b1, 32'h12, 32'h12, 1'b0, 0, 2, 1};
        vecs[11] = '{1'b0, 1'b1, 32'h13, 32'h13, 1'b0, 0, 3, 1};
        vecs[12] = '{1'b0, 1'b1, 32'h14, 32'h14, 1'b0, 0, 4, 1};
        vecs[13] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b1, 1, 5, 2};
        vecs[14] = '{1'b0, 1'b1, 32'h5, 32'h5, 1'b0, 1, 6, 2};

        idle_all();
        model_reset();
        #1;
        rst = 1'b1;
        #1;
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- table-driven: pass run, valid gap, reset, injected mismatch ----
        for (int k = 0; k < 15; k++) begin
            if (vecs[k].rst_before) do_reset();
            in_valid[0] = vecs[k].valid;
            in_meas[0]  = vecs[k].mv;
            in_ref[0]   = vecs[k].rv;
            tick();
            cmp("tbl_err",       0, 32'(o_err[0]), 32'(vecs[k].exp_err));
            cmp("tbl_err_count", 0, o_ec[0],       32'(vecs[k].exp_ec));
            cmp("tbl_chk_count", 0, o_cc[0],       32'(vecs[k].exp_cc));
            cmp("tbl_state",     0, 32'(o_st[0]),  32'(vecs[k].exp_st));
            if (k == 7) cmp("tbl_sticky_clean", 0, 32'(o_sticky[0]), 32'h0);
        end
        cmp("first_meas", 0, o_fm[0], 32'hDEAD_BEEF);
        cmp("first_ref",  0, o_fr[0], 32'hDEAD_BEEE);
        cmp("first_idx",  0, o_fi[0], 32'd4);
        cmp("sticky_set", 0, 32'(o_sticky[0]), 32'h1);
        idle_all();

        // ---- LATENCY=2, DUT output aligned ----
        do_reset();
        seq_v = '{1, 1, 1, 0, 0};
        seq_r = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd0};
        seq_m = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3};
        for (int k = 0; k < 5; k++) begin
            in_valid[1] = seq_v[k][0]; in_ref[1] = seq_r[k]; in_meas[1] = seq_m[k];
            tick();
            if (k < 2) cmp("lat2_no_early_cmp", 1, o_cc[1], 32'd0);
            cmp("lat2_no_err", 1, 32'(o_err[1]), 32'h0);
        end
        cmp("lat2_chk_count", 1, o_cc[1], 32'd3);
        cmp("lat2_state",     1, 32'(o_st[1]), 32'd1);

        // ---- LATENCY=2, DUT output one cycle early ----
        do_reset();
        seq_m = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        for (int k = 0; k < 5; k++) begin
            in_valid[1] = seq_v[k][0]; in_ref[1] = seq_r[k]; in_meas[1] = seq_m[k];
            tick();
            if (k == 2) cmp("lat2_skew_err_pulse", 1, 32'(o_err[1]), 32'h1);
        end
        cmp("lat2_skew_err_count", 1, o_ec[1], 32'd3);
        cmp("lat2_skew_first_idx", 1, o_fi[1], 32'd0);
        cmp("lat2_skew_first_meas", 1, o_fm[1], 32'd2);
        cmp("lat2_skew_first_ref", 1, o_fr[1], 32'd1);
        cmp("lat2_skew_state",     1, 32'(o_st[1]), 32'd2);
        idle_all();

        // ---- LATENCY=3, MAX_ERRORS=3: continuous mismatches halt ----
        do_reset();
        for (int k = 0; k < 8; k++) begin
            in_valid[2] = 1'b1; in_ref[2] = 32'(k); in_meas[2] = 32'hFFFF_FFFF;
            tick();
            if (k == 5) begin
                cmp("halt_last_pulse", 2, 32'(o_err[2]), 32'h1);
                cmp("halt_state",      2, 32'(o_st[2]),  32'd3);
            end
        end
        cmp("halt_err_low",    2, 32'(o_err[2]), 32'h0);
        cmp("halt_err_count",  2, o_ec[2], 32'd3);
        cmp("halt_chk_frozen", 2, o_cc[2], 32'd3);

        // ---- mid-stream reset, LATENCY=3: first compare on 4th edge ----
        in_ref[2] = 32'd7; in_meas[2] = 32'd7;
        do_reset();
        cmp("rst_state_idle", 2, 32'(o_st[2]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) cmp("rst_no_early_cmp", 2, o_cc[2], 32'd0);
        end
        cmp("rst_first_cmp", 2, o_cc[2], 32'd1);
        cmp("rst_run_state", 2, 32'(o_st[2]), 32'd1);
        idle_all();

        // ---- CNTWIDTH=4, MAX_ERRORS=1: saturation, then halt ----
        do_reset();
        for (int k = 0; k < 20; k++) begin
            in_valid[3] = 1'b1; in_ref[3] = 32'(k); in_meas[3] = 32'(k);
            tick();
        end
        cmp("sat_chk_count", 3, o_cc[3], 32'd15);
        cmp("sat_state",     3, 32'(o_st[3]), 32'd1);
        in_meas[3] = 32'h1234; in_ref[3] = 32'h4321;
        tick();
        cmp("sat_first_idx", 3, o_fi[3], 32'd15);
        cmp("sat_halt",      3, 32'(o_st[3]), 32'd3);
        tick();
        cmp("sat_halt_err_low", 3, 32'(o_err[3]), 32'h0);
        cmp("sat_halt_ec",      3, o_ec[3], 32'd1);
        do_reset();
        tick();
        cmp("idle_to_halt", 3, 32'(o_st[3]), 32'd3);
        cmp("idle_to_halt_ec", 3, o_ec[3], 32'd1);
        idle_all();

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 0) do_reset();
            for (int i = 0; i < 4; i++) begin
                in_valid[i] = ($urandom_range(0, 3) != 0);
                in_ref[i]   = $urandom;
                if (P_LAT[i] == 0) aligned = in_ref[i];
                else aligned = hr[i][P_LAT[i]-1];
                if ($urandom_range(0, 15) == 0)
                    in_meas[i] = aligned ^ (32'h1 << $urandom_range(0, 31));
                else
                    in_meas[i] = aligned;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
